// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control unit: FSM state encoding and
// default button-conditioning parameters.
package stopwatch_pkg;

   localparam logic [1:0] ST_STOP  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_CLEAR = 2'b10;

   localparam int DEFAULT_SYNC_STAGES     = 2;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// One button path: multi-flop synchronizer, level debouncer and rising-edge
// detector producing a single-cycle press pulse.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;
   logic [CNT_W-1:0]       cnt_r;
   logic                   level_r;
   logic                   level_d_r;

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Synchronizer chain for the raw asynchronous button.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
      end
   end

   // Debouncer: accept a new level only after it has differed for the full window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r     <= {CNT_W{1'b0}};
         level_r   <= 1'b0;
         level_d_r <= 1'b0;
      end else begin
         level_d_r <= level_r;
         if (sync_s == level_r) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (cnt_r == CNT_LAST) begin
            level_r <= sync_s;
            cnt_r   <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Only the debounced rising edge is an event; release is silent.
   assign press = level_r & ~level_d_r;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: conditions three buttons and runs the
// STOP/RUN/CLEAR FSM with registered Moore outputs and a lap-hold flag.
module stopwatch_cu
   import stopwatch_pkg::*;
#(
   parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_btn_runstop,
   input  logic       i_btn_clear,
   input  logic       i_btn_lap,
   output logic       o_runstop,
   output logic       o_clear,
   output logic       o_lap_hold,
   output logic [1:0] o_state
);

   logic       press_runstop_s;
   logic       press_clear_s;
   logic       press_lap_s;
   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic       hold_nxt_s;
   logic       runstop_r;
   logic       clear_r;
   logic       lap_hold_r;

   btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_runstop (
      .clk(clk), .reset(reset), .btn(i_btn_runstop), .press(press_runstop_s)
   );

   btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk(clk), .reset(reset), .btn(i_btn_clear), .press(press_clear_s)
   );

   btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
      .clk(clk), .reset(reset), .btn(i_btn_lap), .press(press_lap_s)
   );

   // Next state and lap-hold; runstop outranks clear and lap, losers are dropped.
   always_comb begin
      state_nxt_s = ST_STOP;
      hold_nxt_s  = lap_hold_r;
      case (state_r)
         ST_STOP: begin
            if (press_runstop_s) begin
               state_nxt_s = ST_RUN;
            end else if (press_clear_s) begin
               state_nxt_s = ST_CLEAR;
               hold_nxt_s  = 1'b0;
            end else if (press_lap_s) begin
               state_nxt_s = ST_STOP;
               hold_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         ST_RUN: begin
            if (press_runstop_s) begin
               state_nxt_s = ST_STOP;
            end else if (press_lap_s) begin
               state_nxt_s = ST_RUN;
               hold_nxt_s  = ~lap_hold_r;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_CLEAR: begin
            state_nxt_s = ST_STOP;
            hold_nxt_s  = 1'b0;
         end
         default: begin
            state_nxt_s = ST_STOP;
         end
      endcase
   end

   // State register with outputs decoded from the next state so they align with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_STOP;
         runstop_r  <= 1'b0;
         clear_r    <= 1'b0;
         lap_hold_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         runstop_r  <= (state_nxt_s == ST_RUN);
         clear_r    <= (state_nxt_s == ST_CLEAR);
         lap_hold_r <= hold_nxt_s;
      end
   end

   assign o_runstop  = runstop_r;
   assign o_clear    = clear_r;
   assign o_lap_hold = lap_hold_r;
   assign o_state    = state_r;

endmodule

// File: doc/stopwatch_cu.md
STOPWATCH_CU -- requirements
Module: stopwatch_cu

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of input synchronizer flops per button (minimum 2).
REQ-002 Parameter: DEBOUNCE_CYCLES, 1_000_000, consecutive stable clk cycles needed before a button level is accepted (10 ms at 100 MHz).
REQ-003 Port: clk  input  1  system clock, 100 MHz.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: i_btn_runstop  input  1  raw, asynchronous, bouncing run/stop button; active-high.
REQ-006 Port: i_btn_clear  input  1  raw clear button; active-high.
REQ-007 Port: i_btn_lap  input  1  raw lap (display hold) button; active-high.
REQ-008 Port: o_runstop  output  1  high while the counter datapath shall advance; drives the 100 Hz tick generator enable.
REQ-009 Port: o_clear  output  1  single-cycle synchronous clear to all time counters.
REQ-010 Port: o_lap_hold  output  1  high while the display shall show a frozen time value.
REQ-011 Port: o_state  output  2  current FSM state encoding, for debug and LEDs.

Function
REQ-012 Each button path: SYNC_STAGES-flop synchronizer, then a debouncer, then a rising-edge detector producing a one-cycle press pulse.
REQ-013 Debouncer: counter clears whenever the synchronized input equals the debounced level; the debounced level takes the synchronized value once the input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 Input pulses or glitches shorter than DEBOUNCE_CYCLES cycles after synchronization produce no press pulse.
REQ-015 Button release (debounced falling edge) produces no event; a held button produces exactly one press.
REQ-016 Press latency: an effect on the FSM outputs appears SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk edges after the raw input rises and stays stable.
REQ-017 FSM states: STOP = 2'b00, RUN = 2'b01, CLEAR = 2'b10; 2'b11 is illegal and returns to STOP on the next edge.
REQ-018 STOP: runstop press -> RUN; else clear press -> CLEAR; else stay.
REQ-019 RUN: runstop press -> STOP; clear press is ignored; lap press toggles o_lap_hold.
REQ-020 CLEAR: unconditionally -> STOP on the next edge; all presses in CLEAR are ignored.
REQ-021 Outputs are registered Moore outputs: o_runstop = 1 only in RUN; o_clear = 1 only in CLEAR, i.e. exactly one cycle per clear.
REQ-022 o_lap_hold is forced to 0 when entering CLEAR; in STOP a lap press clears o_lap_hold when it is 1 and is ignored otherwise.
REQ-023 Simultaneous presses: runstop has priority over clear and lap in the same cycle; the lower-priority press is discarded, not queued.

Reset
REQ-024 On reset: state STOP, o_runstop 0, o_clear 0, o_lap_hold 0, o_state 2'b00, all synchronizer flops, debounced levels and debounce counters 0.
REQ-025 A button held through reset release yields one press after the full REQ-016 latency.

Structure
REQ-026 The package stopwatch_pkg holds the state encoding constants and the default DEBOUNCE_CYCLES value; the datapath and the top level share it.
REQ-027 Sub-module btn_debounce (synchronizer + debouncer + edge detector, parameterized by SYNC_STAGES and DEBOUNCE_CYCLES) is instantiated three times.
REQ-028 Debounce counter width is $clog2(DEBOUNCE_CYCLES); no other arithmetic is present in the block.

Verification (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2)
REQ-029 Reset released; i_btn_runstop high for 10 cycles -> o_runstop rises exactly 7 edges after the input rises, o_state = 01; release -> no change.
REQ-030 i_btn_runstop pulsed high for 3 cycles, repeated 5 times with 2-cycle gaps -> o_runstop stays 0, o_state stays 00.
REQ-031 In STOP, press clear -> o_clear high for exactly 1 cycle, o_state 10 then 00, o_runstop remains 0.
REQ-032 In RUN, press clear -> ignored (o_clear 0); press lap -> o_lap_hold 1; press lap again -> 0; lap then runstop -> STOP with hold 1; clear -> hold 0.
REQ-033 In STOP, runstop and clear raised in the same cycle -> RUN, o_clear never asserted.
REQ-034 In RUN with o_lap_hold = 1, assert reset for 2 cycles with i_btn_runstop held high -> all outputs 0 immediately; after release, RUN is re-entered 7 edges later.
